// File: rtl/t16q_mmio_pkg.sv
// Shared UART TX definitions: FSM state encoding, default bit timing, MMIO addresses.
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
package t16q_mmio_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200 baud

    localparam logic [15:0] UART_TX_DATA_ADDR = 16'hFF00;
    localparam logic [15:0] UART_STATUS_ADDR  = 16'hFF04;
    localparam logic [15:0] UART_CTRL_ADDR    = 16'hFF08;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
    } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_queue_if.sv
// MMIO-side bundle of the UART TX queue: store strobe/data, overflow clear, status and line.
interface uart_tx_queue_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic       uart_tx;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  full, empty, busy, overflow, uart_tx
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output full, empty, busy, overflow, uart_tx
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; head is visible combinationally on rdata.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Push while full is only legal together with a pop; the old head is read before it is overwritten.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/uart_tx_queue.sv
// Byte-queued UART transmitter: MMIO stores land in a FIFO, the FSM serialises 8N1 frames.
// Build option: UART_TX_PARITY_EN inserts an even-parity bit (8E1, 11-bit frame).
import t16q_mmio_pkg::*;

module uart_tx_queue #(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DEPTH        = 8
) (
    input  logic          clkin,
    input  logic          reset_n,
    uart_tx_queue_if.slave bus
);
    uart_state_e state;
    logic [15:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  sh;
    logic        line;
    logic        ovf;
`ifdef UART_TX_PARITY_EN
    logic        par;
`endif

    logic [7:0] head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bit_end;
    logic       pop;
    logic       push;
    logic       drop;

    assign bit_end = (cnt == 16'(CLKS_PER_BIT - 1));
    // The head leaves the FIFO exactly when a frame starts, from IDLE or straight out of STOP.
    assign pop  = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));
    assign push = bus.wr_en && (!fifo_full || pop);
    assign drop = bus.wr_en && !push;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clkin),
        .rst_n (reset_n),
        .push  (push),
        .wdata (bus.wr_data),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            line  <= 1'b1;
            ovf   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            ovf <= drop || (ovf && !bus.clr_ovf);
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (!fifo_empty) begin
                        sh    <= head;
`ifdef UART_TX_PARITY_EN
                        par   <= ^head;
`endif
                        line  <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        line  <= sh[0];
                        state <= ST_DATA;
                    end else cnt <= cnt + 16'd1;
                end
                ST_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            line  <= par;
                            state <= ST_PARITY;
`else
                            line  <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            idx  <= idx + 3'd1;
                            sh   <= {1'b0, sh[7:1]};
                            line <= sh[1];
                        end
                    end else cnt <= cnt + 16'd1;
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        line  <= 1'b1;
                        state <= ST_STOP;
                    end else cnt <= cnt + 16'd1;
                end
`endif
                ST_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        // Chain the next frame with no idle gap when bytes are waiting.
                        if (!fifo_empty) begin
                            sh    <= head;
`ifdef UART_TX_PARITY_EN
                            par   <= ^head;
`endif
                            line  <= 1'b0;
                            state <= ST_START;
                        end else begin
                            line  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end else cnt <= cnt + 16'd1;
                end
                default: begin
                    cnt   <= '0;
                    line  <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.uart_tx  = line;
    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.busy     = (state != ST_IDLE) || !fifo_empty;
    assign bus.overflow = ovf;
endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomised + directed bench for uart_tx_queue against a frame-timeline reference model.
module tb_uart_tx_queue;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = CPB * NB;

    logic clkin   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;

    uart_tx_queue_if bus();

    uart_tx_queue #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clkin   (clkin),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clkin = ~clkin;

    // Reference model: a byte queue plus the waveform of the frame currently on the line.
    logic [7:0] mq[$];
    bit         in_frame = 1'b0;
    int         mt       = 0;
    bit         mo       = 1'b0;
    logic       fb [0:10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit         fullm;
        bit         popn;
        bit         acc;
        logic [7:0] b;
        fullm = (mq.size() == DEPTH);
        popn  = (mq.size() > 0) && (!in_frame || mt == FRAME - 1);
        acc   = bus.wr_en && (!fullm || popn);
        mo    = (bus.wr_en && !acc) || (mo && !bus.clr_ovf);
        if (in_frame) begin
            mt++;
            if (mt == FRAME) in_frame = 1'b0;
        end
        if (popn) begin
            b     = mq.pop_front();
            fb[0] = 1'b0;
            for (int i = 0; i < 8; i++) fb[i+1] = b[i];
            fb[9]  = (NB == 11) ? ^b : 1'b1;
            fb[10] = 1'b1;
            in_frame = 1'b1;
            mt       = 0;
        end
        if (acc) mq.push_back(bus.wr_data);
    endtask

    function automatic logic exp_line();
        return in_frame ? fb[mt / CPB] : 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clkin or negedge reset_n);
            if (!reset_n) begin
                mq.delete();
                in_frame = 1'b0;
                mt       = 0;
                mo       = 1'b0;
            end else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clkin);
            chk("uart_tx",  bus.uart_tx,  exp_line());
            chk("full",     bus.full,     mq.size() == DEPTH);
            chk("empty",    bus.empty,    mq.size() == 0);
            chk("busy",     bus.busy,     in_frame || mq.size() > 0);
            chk("overflow", bus.overflow, mo);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic write(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        @(negedge clkin);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int c = 0;
        while (bus.busy && c < maxc) begin
            @(negedge clkin);
            c++;
        end
        chk("drain", bus.busy, 1'b0);
    endtask

    task automatic wait_t(input int tt, input string nm);
        int c = 0;
        while (!(in_frame && mt == tt) && c < 1000) begin
            @(negedge clkin);
            c++;
        end
        chk(nm, c < 1000, 1'b1);
    endtask

    // Writes one byte into the idle queue and returns the mid-bit line level of every frame bit.
    task automatic capture(input logic [7:0] b, output logic [10:0] w);
        write(b);
        chk("lat_pre_low", bus.uart_tx, 1'b1);
        chk("lat_busy",    bus.busy,    1'b1);
        w = '0;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clkin);
            if (j % CPB == 1) w[j / CPB] = bus.uart_tx;
        end
        @(negedge clkin);
        chk("frame_end_busy", bus.busy,    1'b0);
        chk("frame_end_line", bus.uart_tx, 1'b1);
    endtask

    logic [10:0] w;
    logic        s  [0:8*11];
    logic        bz [0:8*11];
    int          pv [3] = '{5, 25, 70};
    int          p;

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        @(negedge clkin);
        chk("rst_uart_tx",  bus.uart_tx,  1'b1);
        chk("rst_empty",    bus.empty,    1'b1);
        chk("rst_full",     bus.full,     1'b0);
        chk("rst_busy",     bus.busy,     1'b0);
        chk("rst_overflow", bus.overflow, 1'b0);
        repeat (2) @(negedge clkin);
        reset_n = 1'b1;
        repeat (3) @(negedge clkin);

        // Single frames with literal waveforms.
        capture(8'h55, w);
`ifdef UART_TX_PARITY_EN
        chk("frame_55", w, 11'b10010101010);
        capture(8'h07, w);
        chk("frame_07_par1", w, 11'b11000001110);
        capture(8'h03, w);
        chk("frame_03_par0", w, 11'b10000000110);
`else
        chk("frame_55", w, 11'b01010101010);
        capture(8'h07, w);
        chk("frame_07", w, 11'b01000001110);
`endif

        // Back-to-back frames: no gap between stop and next start.
        bus.wr_en = 1'b1;  bus.wr_data = 8'h00;
        @(negedge clkin);
        bus.wr_data = 8'hFF;
        @(negedge clkin);
        bus.wr_en = 1'b0;
        for (int j = 0; j <= 2 * FRAME; j++) begin
            s[j]  = bus.uart_tx;
            bz[j] = bus.busy;
            if (j < 2 * FRAME) @(negedge clkin);
        end
        chk("b2b_f1_start", s[0],             1'b0);
        chk("b2b_f1_data0", s[CPB + 1],       1'b0);
        chk("b2b_f1_stop",  s[FRAME - 1],     1'b1);
        chk("b2b_f2_start", s[FRAME],         1'b0);
        chk("b2b_f2_data0", s[FRAME + CPB + 1], 1'b1);
        chk("b2b_f2_stop",  s[2 * FRAME - 1], 1'b1);
        chk("b2b_busy_end", bz[2 * FRAME - 1], 1'b1);
        chk("b2b_idle_end", bz[2 * FRAME],    1'b0);

        // Overflow: one frame running, nine more writes, the ninth is dropped.
        write(8'hA1);
        @(negedge clkin);
        bus.wr_en = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.wr_data = 8'h10 + 8'(i);
            @(negedge clkin);
        end
        bus.wr_en = 1'b0;
        chk("ovf_full", bus.full,     1'b1);
        chk("ovf_set",  bus.overflow, 1'b1);
        bus.clr_ovf = 1'b1;
        @(negedge clkin);
        bus.clr_ovf = 1'b0;
        chk("ovf_clr",  bus.overflow, 1'b0);
        wait_idle((DEPTH + 2) * FRAME);

        // Write while full lands in the pop cycle and must be accepted.
        write(8'h30);
        bus.wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            bus.wr_data = 8'h30 + 8'(i);
            @(negedge clkin);
        end
        bus.wr_en = 1'b0;
        chk("popw_full_before", bus.full, 1'b1);
        wait_t(FRAME - 1, "popw_reach");
        write(8'hC3);
        chk("popw_no_ovf",     bus.overflow, 1'b0);
        chk("popw_full_after", bus.full,     1'b1);
        wait_idle((DEPTH + 2) * FRAME);

        // Reset during the third data bit with three bytes queued.
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h00;
        repeat (4) @(negedge clkin);
        bus.wr_en = 1'b0;
        wait_t(3 * CPB + 1, "rst_reach");
        chk("rst_pre_low", bus.uart_tx, 1'b0);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_uart_tx", bus.uart_tx, 1'b1);
        chk("midrst_empty",   bus.empty,   1'b1);
        chk("midrst_busy",    bus.busy,    1'b0);
        repeat (2) @(negedge clkin);
        reset_n = 1'b1;
        repeat (20) @(negedge clkin);
        chk("post_rst_line", bus.uart_tx, 1'b1);
        chk("post_rst_busy", bus.busy,    1'b0);

        // Random traffic with varying write density, random clears and occasional resets.
        p = pv[0];
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) p = pv[$urandom_range(2)];
            bus.wr_en   = ($urandom_range(99) < p);
            bus.wr_data = 8'($urandom);
            bus.clr_ovf = ($urandom_range(63) == 0);
            if ($urandom_range(999) == 0) begin
                #2 reset_n = 1'b0;
                @(negedge clkin);
                #2 reset_n = 1'b1;
            end
            @(negedge clkin);
        end
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
        wait_idle((DEPTH + 2) * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
